char_console_writer: RTL and testbench
======================================

// Module: char_console_writer
// PURPOSE
//  Terminal-style writer that sits directly upstream of the character RAM and drives its write port.
//  - Accepts an ASCII byte stream over a valid/ready handshake.
//  - Keeps a row/column cursor.
//  - Handles control codes.
//  - Turns each character into one registered RAM write (wea/addra/dia).
//  - Text producers (e.g. the Fibonacci formatter) print without computing screen addresses.
// PARAMETERS
//  COLS    64     characters per row; power of 2
//  ROWS    16     rows on screen; COLS*ROWS <= 1024 (RAM depth)
//  ADDR_W  14     RAM address width (matches char RAM port)
//  BLANK   8'h20  fill character (ASCII space)
// PORTS
//  clk         in   1       single clock; also drives the char RAM write clock
//  rst_n       in   1       synchronous reset, active-low
//  char_valid  in   1       char_data is valid
//  char_data   in   8       ASCII byte
//  char_ready  out  1       writer can accept a byte this cycle
//  busy        out  1       clear sweep in progress
//  wea         out  1       char RAM write enable
//  addra       out  ADDR_W  char RAM write address = row*COLS + col
//  dia         out  8       char RAM write data
//  cur_row     out  4       cursor row, 0..ROWS-1
//  cur_col     out  6       cursor column, 0..COLS-1
// BEHAVIOUR
//  Reset values (rst_n low at a clk edge):
//   - wea=0, addra=0, dia=BLANK, char_ready=0, busy=1, cursor=(0,0).
//   - State goes to CLR_ALL, clear pointer=0.
//  Handshake:
//   - A byte is accepted on a clk edge with char_valid & char_ready.
//   - char_ready = (state==IDLE), decoded from the state register.
//   - Back-to-back printables are accepted every cycle.
//  Output timing: all RAM outputs are registered.
//   - A byte accepted at edge N produces its write (if any) during cycle N..N+1.
//   - The cursor updates at the same edge.
//  States:
//   - IDLE:
//     - printable 0x20-0x7E: write char at cursor, col+1.
//     - LF 0x0A: col=0, row+1, go to CLR_ROW.
//     - CR 0x0D: col=0, no write.
//     - BS 0x08: if col>0, col-1 and write BLANK at the new col; at col 0, no write and no move.
//     - FF 0x0C: cursor=(0,0), go to CLR_ALL.
//     - Any other byte: accepted and dropped.
//   - CLR_ROW:
//     - Writes BLANK to the cursor row, cols 0..COLS-1, one per cycle (exactly COLS cycles).
//     - Then returns to IDLE.
//   - CLR_ALL:
//     - Writes BLANK to addresses 0..COLS*ROWS-1, one per cycle.
//     - Then returns to IDLE.
//   - busy=1 only in CLR_ALL. char_ready=0 in both clear states.
//  Wrap rules:
//   - Printable at col COLS-1: col=0, row+1, enter CLR_ROW (new row is blanked).
//   - Any row increment from ROWS-1 wraps to row 0. No scrolling.
//  Arithmetic: addra = {row, col} zero-extended to ADDR_W, since COLS is a power of 2.
//  Reset mid-sweep (or in any state):
//   - Aborts the operation immediately.
//   - A full CLR_ALL restarts from address 0 after rst_n rises.
//  char_valid during a clear state is held off; the byte is not lost, since it is not accepted.
// STRUCTURE
//  - Shared header char_console_defs.vh holds:
//    - ASCII codes: LF, CR, BS, FF, BLANK.
//    - State encodings: IDLE, CLR_ROW, CLR_ALL.
//    - Default geometry: COLS, ROWS.
//  - One sub-module, char_cursor:
//    - Holds the row/col registers.
//    - Handles advance, wrap, CR and BS.
//    - Produces the flat address.
//  - The top holds the FSM, clear counter and output registers.
// TESTING
//  1. Release rst_n:
//     - Exactly 1024 cycles of wea=1, dia=0x20, addra 0..1023 in order, busy=1.
//     - char_ready=1 on the next cycle.
//  2. After the clear, send 'A','B' back to back:
//     - Writes addr 0 dia 0x41, then addr 1 dia 0x42 on consecutive cycles.
//     - cur_col=2.
//  3. Cursor at (0,5), send LF:
//     - Cursor becomes (1,0).
//     - 64 writes of 0x20 to addr 64..127, with char_ready=0 throughout.
//     - Then ready=1.
//  4. Cursor at (15,63), send 'Z':
//     - Write addr 1023 dia 0x5A.
//     - Cursor becomes (0,0); addr 0..63 are blanked.
//  5. BS at (2,3): write 0x20 to addr 130, cur_col=2. BS at (2,0): no write, cursor unchanged.
//  6. Send FF, and pull rst_n low for 1 cycle at sweep address 500:
//     - Reset outputs are seen.
//     - The sweep restarts at addr 0 and completes all 1024 writes.

Source files
------------

// File: rtl/char_console_writer_pkg.sv
// Shared definitions for the character console writer: screen geometry,
// ASCII control codes, FSM states and cursor commands.
package char_console_writer_pkg;

   localparam int COLS       = 64;
   localparam int ROWS       = 16;
   localparam int COL_W      = 6;
   localparam int ROW_W      = 4;
   localparam int CELL_W     = ROW_W + COL_W;
   localparam int CLR_W      = CELL_W + 1;
   localparam int RAM_ADDR_W = 14;

   localparam logic [7:0] ASCII_BS    = 8'h08;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_FF    = 8'h0C;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] BLANK       = 8'h20;
   localparam logic [7:0] PRINTABLE_LO = 8'h20;
   localparam logic [7:0] PRINTABLE_HI = 8'h7E;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLR_ROW,
      ST_CLR_ALL
   } state_t;

   typedef enum logic [2:0] {
      CUR_HOLD,
      CUR_ADVANCE,
      CUR_NEWLINE,
      CUR_RETURN,
      CUR_BACK,
      CUR_HOME
   } cur_cmd_t;

   function automatic logic is_printable(input logic [7:0] c);
      return (c >= PRINTABLE_LO) && (c <= PRINTABLE_HI);
   endfunction

endpackage

// File: rtl/char_console_writer_if.sv
// Byte-stream handshake into the console writer: the producer drives
// char_valid/char_data, the writer answers with char_ready.
interface char_console_writer_if;

   logic       char_valid;
   logic [7:0] char_data;
   logic       char_ready;

   modport master (output char_valid, output char_data, input char_ready);
   modport slave  (input char_valid, input char_data, output char_ready);

endinterface

// File: rtl/char_console_writer_cursor.sv
// Row/column cursor for the console writer. Handles advance with line wrap,
// newline, carriage return, backspace and home, and exposes flat cell addresses.
module char_cursor
   import char_console_writer_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  cur_cmd_t          cmd,
   output logic [ROW_W-1:0]  row,
   output logic [COL_W-1:0]  col,
   output logic [CELL_W-1:0] cell_addr,
   output logic [CELL_W-1:0] back_addr,
   output logic              at_last_col,
   output logic              at_first_col
);

   assign at_last_col  = (col == COL_W'(COLS - 1));
   assign at_first_col = (col == '0);
   assign cell_addr    = {row, col};
   assign back_addr    = {row, col - COL_W'(1)};

   // ROWS is a power of two, so the row counter wraps to 0 on its own.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row <= '0;
         col <= '0;
      end else begin
         unique case (cmd)
            CUR_ADVANCE: begin
               if (at_last_col) begin
                  col <= '0;
                  row <= row + ROW_W'(1);
               end else begin
                  col <= col + COL_W'(1);
               end
            end
            CUR_NEWLINE: begin
               col <= '0;
               row <= row + ROW_W'(1);
            end
            CUR_RETURN: col <= '0;
            CUR_BACK: begin
               if (!at_first_col) col <= col - COL_W'(1);
            end
            CUR_HOME: begin
               row <= '0;
               col <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/char_console_writer.sv
// Terminal-style writer feeding the character RAM write port: decodes the
// byte stream, tracks the cursor and runs row / full-screen blanking sweeps.
module char_console_writer
   import char_console_writer_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   char_console_writer_if.slave char_in,
   output logic                 busy,
   output logic                 wea,
   output logic [ADDR_W-1:0]    addra,
   output logic [7:0]           dia,
   output logic [ROW_W-1:0]     cur_row,
   output logic [COL_W-1:0]     cur_col
);

   state_t            state_q, state_d;
   logic [CLR_W-1:0]  clr_ptr_q, clr_ptr_d;
   logic              wea_d;
   logic [ADDR_W-1:0] addra_d;
   logic [7:0]        dia_d;
   cur_cmd_t          cur_cmd;
   logic [CELL_W-1:0] cell_addr, back_addr;
   logic              at_last_col, at_first_col;
   logic              accept;

   assign char_in.char_ready = (state_q == ST_IDLE);
   assign busy               = (state_q == ST_CLR_ALL);
   assign accept             = char_in.char_valid && char_in.char_ready;

   char_cursor u_cursor (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd          (cur_cmd),
      .row          (cur_row),
      .col          (cur_col),
      .cell_addr    (cell_addr),
      .back_addr    (back_addr),
      .at_last_col  (at_last_col),
      .at_first_col (at_first_col)
   );

   // The clear pointer counts one past the last cell so the final blank write
   // is still visible while the state reads as a clear state.
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      wea_d     = 1'b0;
      addra_d   = addra;
      dia_d     = dia;
      cur_cmd   = CUR_HOLD;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (is_printable(char_in.char_data)) begin
                  wea_d   = 1'b1;
                  addra_d = ADDR_W'(cell_addr);
                  dia_d   = char_in.char_data;
                  cur_cmd = CUR_ADVANCE;
                  if (at_last_col) begin
                     state_d   = ST_CLR_ROW;
                     clr_ptr_d = '0;
                  end
               end else begin
                  unique case (char_in.char_data)
                     ASCII_LF: begin
                        cur_cmd   = CUR_NEWLINE;
                        state_d   = ST_CLR_ROW;
                        clr_ptr_d = '0;
                     end
                     ASCII_CR: cur_cmd = CUR_RETURN;
                     ASCII_BS: begin
                        if (!at_first_col) begin
                           cur_cmd = CUR_BACK;
                           wea_d   = 1'b1;
                           addra_d = ADDR_W'(back_addr);
                           dia_d   = BLANK;
                        end
                     end
                     ASCII_FF: begin
                        cur_cmd   = CUR_HOME;
                        state_d   = ST_CLR_ALL;
                        clr_ptr_d = '0;
                     end
                     default: ;
                  endcase
               end
            end
         end
         ST_CLR_ROW: begin
            if (clr_ptr_q == CLR_W'(COLS)) begin
               state_d = ST_IDLE;
            end else begin
               wea_d     = 1'b1;
               addra_d   = ADDR_W'({cur_row, clr_ptr_q[COL_W-1:0]});
               dia_d     = BLANK;
               clr_ptr_d = clr_ptr_q + CLR_W'(1);
            end
         end
         ST_CLR_ALL: begin
            if (clr_ptr_q == CLR_W'(COLS * ROWS)) begin
               state_d = ST_IDLE;
            end else begin
               wea_d     = 1'b1;
               addra_d   = ADDR_W'(clr_ptr_q[CELL_W-1:0]);
               dia_d     = BLANK;
               clr_ptr_d = clr_ptr_q + CLR_W'(1);
            end
         end
         default: state_d = ST_CLR_ALL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_CLR_ALL;
         clr_ptr_q <= '0;
         wea       <= 1'b0;
         addra     <= '0;
         dia       <= BLANK;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         wea       <= wea_d;
         addra     <= addra_d;
         dia       <= dia_d;
      end
   end

endmodule

// File: tb/tb_char_console_writer.sv
// Directed bench for char_console_writer: power-up clear, printing, newline and
// wrap sweeps, backspace/CR/ignored bytes, and reset in the middle of a clear.
module tb_char_console_writer;
   import char_console_writer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        busy, wea;
   logic [13:0] addra;
   logic [7:0]  dia;
   logic [3:0]  cur_row;
   logic [5:0]  cur_col;
   int          checks = 0;
   int          errors = 0;

   char_console_writer_if char_if ();

   always #5 clk = ~clk;

   char_console_writer dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .char_in (char_if),
      .busy    (busy),
      .wea     (wea),
      .addra   (addra),
      .dia     (dia),
      .cur_row (cur_row),
      .cur_col (cur_col)
   );

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input int budget);
      int n = 0;
      while (char_if.char_ready !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check_output("ready_wait", 32'(char_if.char_ready), 32'd1);
   endtask

   task automatic apply_stimulus(input logic [7:0] b);
      wait_ready(2000);
      char_if.char_valid = 1'b1;
      char_if.char_data  = b;
      tick();
      char_if.char_valid = 1'b0;
   endtask

   // Each sample packs {wea, addra, dia, busy, char_ready} of one blanking write.
   task automatic sweep_check(input string tag, input int base, input int count,
                              input logic busy_exp);
      for (int i = 0; i < count; i++) begin
         tick();
         check_output(tag, {7'd0, wea, addra, dia, busy, char_if.char_ready},
                      {7'd0, 1'b1, 14'(base + i), 8'h20, busy_exp, 1'b0});
      end
   endtask

   task automatic check_reset_state(input string tag);
      check_output({tag, "_wea"},   32'(wea),                32'd0);
      check_output({tag, "_addra"}, 32'(addra),              32'd0);
      check_output({tag, "_dia"},   32'(dia),                32'h20);
      check_output({tag, "_ready"}, 32'(char_if.char_ready), 32'd0);
      check_output({tag, "_busy"},  32'(busy),               32'd1);
      check_output({tag, "_row"},   32'(cur_row),            32'd0);
      check_output({tag, "_col"},   32'(cur_col),            32'd0);
   endtask

   initial begin
      rst_n              = 1'b0;
      char_if.char_valid = 1'b0;
      char_if.char_data  = 8'h00;
      tick();
      tick();
      check_reset_state("rst");

      // Power-up clear: 1024 blank writes, then ready
      rst_n = 1'b1;
      sweep_check("init_sweep", 0, 1024, 1'b1);
      tick();
      check_output("init_ready", 32'(char_if.char_ready), 32'd1);
      check_output("init_wea",   32'(wea),                32'd0);
      check_output("init_busy",  32'(busy),               32'd0);

      // Back-to-back printables
      apply_stimulus(8'h41);
      check_output("A_write", {9'd0, wea, addra, dia}, {9'd0, 1'b1, 14'd0, 8'h41});
      check_output("A_col",   32'(cur_col), 32'd1);
      apply_stimulus(8'h42);
      check_output("B_write", {9'd0, wea, addra, dia}, {9'd0, 1'b1, 14'd1, 8'h42});
      check_output("B_col",   32'(cur_col), 32'd2);
      tick();
      check_output("B_idle_wea", 32'(wea), 32'd0);

      // Line feed from (0,5) with a byte held off during the row clear
      apply_stimulus(8'h43);
      apply_stimulus(8'h44);
      apply_stimulus(8'h45);
      check_output("pre_lf_col", 32'(cur_col), 32'd5);
      apply_stimulus(ASCII_LF);
      check_output("lf_row",   32'(cur_row),            32'd1);
      check_output("lf_col",   32'(cur_col),            32'd0);
      check_output("lf_wea",   32'(wea),                32'd0);
      check_output("lf_ready", 32'(char_if.char_ready), 32'd0);
      char_if.char_valid = 1'b1;
      char_if.char_data  = 8'h51;
      sweep_check("lf_sweep", 64, 64, 1'b0);
      tick();
      check_output("lf_done_ready", 32'(char_if.char_ready), 32'd1);
      check_output("lf_done_wea",   32'(wea),                32'd0);
      tick();
      char_if.char_valid = 1'b0;
      check_output("held_Q_write", {9'd0, wea, addra, dia}, {9'd0, 1'b1, 14'd64, 8'h51});
      check_output("held_Q_col",   32'(cur_col), 32'd1);

      // Walk to (15,63), then wrap with 'Z'
      for (int i = 0; i < 14; i++) apply_stimulus(ASCII_LF);
      for (int i = 0; i < 63; i++) apply_stimulus(8'h78);
      check_output("pre_Z_pos", {22'd0, cur_row, cur_col}, {22'd0, 4'd15, 6'd63});
      apply_stimulus(8'h5A);
      check_output("Z_write", {9'd0, wea, addra, dia}, {9'd0, 1'b1, 14'd1023, 8'h5A});
      check_output("Z_pos",   {22'd0, cur_row, cur_col}, 32'd0);
      check_output("Z_ready", 32'(char_if.char_ready), 32'd0);
      sweep_check("Z_sweep", 0, 64, 1'b0);
      tick();
      check_output("Z_done_ready", 32'(char_if.char_ready), 32'd1);

      // Backspace at column 0 and at column 3, then CR and an ignored byte
      apply_stimulus(ASCII_LF);
      apply_stimulus(ASCII_LF);
      wait_ready(200);
      apply_stimulus(ASCII_BS);
      check_output("bs0_wea", 32'(wea), 32'd0);
      check_output("bs0_pos", {22'd0, cur_row, cur_col}, {22'd0, 4'd2, 6'd0});
      apply_stimulus(8'h61);
      apply_stimulus(8'h62);
      apply_stimulus(8'h63);
      check_output("pre_bs_col", 32'(cur_col), 32'd3);
      apply_stimulus(ASCII_BS);
      check_output("bs3_write", {9'd0, wea, addra, dia}, {9'd0, 1'b1, 14'd130, 8'h20});
      check_output("bs3_col",   32'(cur_col), 32'd2);
      apply_stimulus(ASCII_CR);
      check_output("cr_wea", 32'(wea), 32'd0);
      check_output("cr_pos", {22'd0, cur_row, cur_col}, {22'd0, 4'd2, 6'd0});
      apply_stimulus(8'h01);
      check_output("drop_wea",   32'(wea),                32'd0);
      check_output("drop_pos",   {22'd0, cur_row, cur_col}, {22'd0, 4'd2, 6'd0});
      check_output("drop_ready", 32'(char_if.char_ready), 32'd1);

      // Form feed, reset at sweep address 500, full sweep restarts
      apply_stimulus(ASCII_FF);
      check_output("ff_pos",  {22'd0, cur_row, cur_col}, 32'd0);
      check_output("ff_busy", 32'(busy), 32'd1);
      check_output("ff_wea",  32'(wea),  32'd0);
      sweep_check("ff_sweep", 0, 501, 1'b1);
      rst_n = 1'b0;
      tick();
      check_reset_state("midrst");
      rst_n = 1'b1;
      sweep_check("restart_sweep", 0, 1024, 1'b1);
      tick();
      check_output("restart_ready", 32'(char_if.char_ready), 32'd1);
      check_output("restart_busy",  32'(busy),               32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
